// File: rtl/res_arb.sv
// res_arb: two-port round-robin arbiter with lock for the shared 16384x8 DT result RAM
//   clk, reset (async, active-low)
//   port A (DT engine) / port B (host): x_req, x_we, x_lock, x_addr, x_wdata in; x_gnt, x_rvalid, x_rdata out
//   RAM side: res_rd, res_wr, res_addr, res_do out (registered); res_di in (valid one cycle after res_rd)
//   optional RES_ARB_STATS_EN: a_beats, b_beats, stall_cycles (16-bit saturating)
module res_arb #(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          res_rd,
  output logic          res_wr,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di
`ifdef RES_ARB_STATS_EN
  ,
  output logic [15:0]   a_beats,
  output logic [15:0]   b_beats,
  output logic [15:0]   stall_cycles
`endif
);
  typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;
  state_t state, state_n;
  logic last_b, last_b_n;
  logic [7:0] cnt, cnt_n;
  logic own_b;
  logic cnt_max;
  logic acc, we;
  assign cnt_max = cnt == 8'(LOCK_MAX);
  assign acc = a_gnt | b_gnt;
  assign we = b_gnt ? b_we : a_we;
  assign a_rdata = res_di;
  assign b_rdata = res_di;
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    state_n = state;
    last_b_n = last_b;
    cnt_n = cnt;
    case (state)
      ARB: begin
        a_gnt = a_req & (~b_req | last_b);
        b_gnt = b_req & ~a_gnt;
        if (a_gnt) begin
          last_b_n = 1'b0;
          state_n = a_lock ? LOCK_A : ARB;
          cnt_n = a_lock ? 8'd1 : 8'd0;
        end else if (b_gnt) begin
          last_b_n = 1'b1;
          state_n = b_lock ? LOCK_B : ARB;
          cnt_n = b_lock ? 8'd1 : 8'd0;
        end
      end
      LOCK_A: begin
        // at the limit with B waiting, A is refused this cycle so B wins the next arbitration
        if (cnt_max && b_req) begin
          state_n = ARB;
          last_b_n = 1'b0;
          cnt_n = 8'd0;
        end else if (a_req) begin
          a_gnt = 1'b1;
          state_n = a_lock ? LOCK_A : ARB;
          last_b_n = a_lock ? last_b : 1'b0;
          cnt_n = !a_lock ? 8'd0 : cnt_max ? cnt : cnt + 8'd1;
        end
      end
      LOCK_B: begin
        if (cnt_max && a_req) begin
          state_n = ARB;
          last_b_n = 1'b1;
          cnt_n = 8'd0;
        end else if (b_req) begin
          b_gnt = 1'b1;
          state_n = b_lock ? LOCK_B : ARB;
          last_b_n = b_lock ? last_b : 1'b1;
          cnt_n = !b_lock ? 8'd0 : cnt_max ? cnt : cnt + 8'd1;
        end
      end
      default: state_n = ARB;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ARB;
      last_b <= 1'b1;
      cnt <= 8'd0;
      res_rd <= 1'b0;
      res_wr <= 1'b0;
      res_addr <= '0;
      res_do <= '0;
      own_b <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      state <= state_n;
      last_b <= last_b_n;
      cnt <= cnt_n;
      res_rd <= acc & ~we;
      res_wr <= acc & we;
      if (acc) begin
        res_addr <= b_gnt ? b_addr : a_addr;
        res_do <= b_gnt ? b_wdata : a_wdata;
        own_b <= b_gnt;
      end
      // RAM data lands one cycle after the strobe, so rvalid follows the strobe by one register
      a_rvalid <= res_rd & ~own_b;
      b_rvalid <= res_rd & own_b;
    end
`ifdef RES_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_beats <= '0;
      b_beats <= '0;
      stall_cycles <= '0;
    end else begin
      a_beats <= a_beats + {15'd0, a_gnt & ~&a_beats};
      b_beats <= b_beats + {15'd0, b_gnt & ~&b_beats};
      stall_cycles <= stall_cycles + {15'd0, ((a_req & ~a_gnt) | (b_req & ~b_gnt)) & ~&stall_cycles};
    end
`endif
endmodule

// File: tb/tb_res_arb.sv
// tb_res_arb: directed self-checking bench for res_arb (LOCK_MAX = 3)
module tb_res_arb;
  logic clk = 1'b0, reset = 1'b0;
  logic a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [13:0] a_addr, b_addr, res_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, res_do, res_di;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, res_rd, res_wr;
  logic [7:0] mem [0:16383];
  int vecs = 0, errs = 0;
`ifdef RES_ARB_STATS_EN
  logic [15:0] a_beats, b_beats, stall_cycles;
`endif
  res_arb #(.AW(14), .DW(8), .LOCK_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
`ifdef RES_ARB_STATS_EN
    , .a_beats(a_beats), .b_beats(b_beats), .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (res_wr) mem[res_addr] <= res_do;
    if (res_rd) res_di <= mem[res_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic seta(input logic r, input logic w, input logic l, input logic [13:0] ad, input logic [7:0] d);
    a_req = r; a_we = w; a_lock = l; a_addr = ad; a_wdata = d;
  endtask
  task automatic setb(input logic r, input logic w, input logic l, input logic [13:0] ad, input logic [7:0] d);
    b_req = r; b_we = w; b_lock = l; b_addr = ad; b_wdata = d;
  endtask
  task automatic gnts(input string tag, input logic ea, input logic eb);
    #1;
    chk({tag, " a_gnt"}, a_gnt, ea);
    chk({tag, " b_gnt"}, b_gnt, eb);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0081] = 8'h05;
    mem[14'h0100] = 8'h33;
    mem[14'h0102] = 8'h11;
    mem[14'h0103] = 8'h22;
    res_di = 8'h00;
    seta(0, 0, 0, 0, 0);
    setb(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst res_rd", res_rd, 0);
    chk("rst res_wr", res_wr, 0);
    chk("rst res_addr", res_addr, 0);
    chk("rst res_do", res_do, 0);
    chk("rst a_rvalid", a_rvalid, 0);
    chk("rst b_rvalid", b_rvalid, 0);
    reset = 1'b1;
    // single read
    seta(1, 0, 0, 14'h0081, 0);
    gnts("single", 1, 0);
    step();
    seta(0, 0, 0, 0, 0);
    chk("single res_rd", res_rd, 1);
    chk("single res_wr", res_wr, 0);
    chk("single res_addr", res_addr, 14'h0081);
    chk("single early rvalid", a_rvalid, 0);
    step();
    chk("single a_rvalid", a_rvalid, 1);
    chk("single a_rdata", a_rdata, 8'h05);
    chk("single b_rvalid", b_rvalid, 0);
    chk("single idle res_rd", res_rd, 0);
    step();
    chk("single rvalid drop", a_rvalid, 0);
    chk("single addr hold", res_addr, 14'h0081);
    // round-robin from reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    seta(1, 0, 0, 14'h0102, 0);
    setb(1, 0, 0, 14'h0103, 0);
    for (int i = 0; i < 4; i++) begin
      gnts("rr", i % 2 == 0, i % 2 == 1);
      chk("rr a_rvalid", a_rvalid, i == 2);
      chk("rr b_rvalid", b_rvalid, i == 3);
      if (i == 2) chk("rr a_rdata", a_rdata, 8'h11);
      if (i == 3) chk("rr b_rdata", b_rdata, 8'h22);
      step();
    end
    seta(0, 0, 0, 0, 0);
    setb(0, 0, 0, 0, 0);
    step();
    step();
    // lock hold, read-modify-write with B waiting
    seta(1, 0, 1, 14'h0102, 0);
    setb(1, 0, 0, 14'h0100, 0);
    gnts("lock0", 1, 0);
    step();
    seta(1, 0, 1, 14'h0103, 0);
    gnts("lock1", 1, 0);
    step();
    seta(1, 1, 0, 14'h0103, 8'h02);
    gnts("lock2", 1, 0);
    chk("lock a_rdata0", a_rdata, 8'h11);
    step();
    seta(0, 0, 0, 0, 0);
    gnts("lock3", 0, 1);
    chk("lock res_wr", res_wr, 1);
    chk("lock res_addr", res_addr, 14'h0103);
    chk("lock res_do", res_do, 8'h02);
    chk("lock pre-write rvalid", a_rvalid, 1);
    chk("lock pre-write rdata", a_rdata, 8'h22);
    step();
    setb(1, 0, 0, 14'h0103, 0);
    gnts("post-write rd", 0, 1);
    step();
    setb(0, 0, 0, 0, 0);
    chk("b rdata 0x100", b_rdata, 8'h33);
    chk("b rvalid 0x100", b_rvalid, 1);
    step();
    chk("post-write rvalid", b_rvalid, 1);
    chk("post-write rdata", b_rdata, 8'h02);
    step();
    // lock starvation limit (LOCK_MAX = 3)
    seta(1, 0, 1, 14'h0081, 0);
    setb(1, 0, 0, 14'h0100, 0);
    for (int i = 0; i < 5; i++) begin
      gnts("starve", i < 3, i == 4);
      step();
    end
    setb(0, 0, 0, 0, 0);
    seta(1, 0, 0, 14'h0081, 0);
    gnts("starve after", 1, 0);
    step();
    // lock owner idle keeps ownership
    seta(1, 0, 1, 14'h0081, 0);
    gnts("idle lock0", 1, 0);
    step();
    seta(0, 0, 0, 0, 0);
    setb(1, 0, 0, 14'h0100, 0);
    gnts("idle lock1", 0, 0);
    step();
    seta(1, 0, 0, 14'h0081, 0);
    gnts("idle lock2", 1, 0);
    step();
    seta(0, 0, 0, 0, 0);
    gnts("idle lock3", 0, 1);
    step();
    setb(0, 0, 0, 0, 0);
    repeat (3) step();
    // reset mid-read
    seta(1, 0, 0, 14'h0081, 0);
    gnts("rstmid", 1, 0);
    step();
    seta(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rstmid res_rd", res_rd, 0);
    step();
    chk("rstmid a_rvalid", a_rvalid, 0);
    reset = 1'b1;
    step();
    chk("rstmid a_rvalid2", a_rvalid, 0);
    seta(1, 0, 0, 14'h0100, 0);
    gnts("rstmid new", 1, 0);
    step();
    seta(0, 0, 0, 0, 0);
    chk("rstmid new res_rd", res_rd, 1);
    chk("rstmid new addr", res_addr, 14'h0100);
    step();
    chk("rstmid new rvalid", a_rvalid, 1);
    chk("rstmid new rdata", a_rdata, 8'h33);
    step();
`ifdef RES_ARB_STATS_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    seta(1, 0, 0, 14'h0081, 0);
    setb(1, 0, 0, 14'h0100, 0);
    repeat (4) step();
    setb(0, 0, 0, 0, 0);
    repeat (8) step();
    seta(0, 0, 0, 0, 0);
    setb(1, 0, 0, 14'h0100, 0);
    repeat (4) step();
    setb(0, 0, 0, 0, 0);
    step();
    chk("stats a_beats", a_beats, 10);
    chk("stats b_beats", b_beats, 6);
    chk("stats stall", stall_cycles, 4);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
